// File: rtl/rll_key_loader_if.sv
// Key beat stream between the on-chip key source (master) and rll_key_loader (slave).
// One beat moves on every rising edge where chunk_valid and chunk_ready are both high.
interface rll_key_loader_if #(
    parameter int CHUNK_W = 8
);
    logic [CHUNK_W-1:0] chunk_data;
    logic               chunk_valid;
    logic               chunk_ready;

    modport master (
        output chunk_data,
        output chunk_valid,
        input  chunk_ready
    );

    modport slave (
        input  chunk_data,
        input  chunk_valid,
        output chunk_ready
    );
endinterface

// File: rtl/rll_key_loader.sv
// Key bus sequencer for a random-logic-locked netlist: beats in, XOR checksum, then key_out.
// Optional feature macro KEY_LOCKOUT_EN adds a LOCKED state after MAX_FAIL consecutive bad checksums.
module rll_key_loader #(
    parameter int KEY_W    = 32,
    parameter int CHUNK_W  = 8,
    parameter int MAX_FAIL = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    rll_key_loader_if.slave      chunk,
    output logic [KEY_W-1:0]     key_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 err,
    output logic                 locked
);

    localparam int N      = KEY_W / CHUNK_W;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
`ifdef KEY_LOCKOUT_EN
        APPLY,
        LOCKED
`else
        APPLY
`endif
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [KEY_W-1:0]   shadow;
    logic [CHUNK_W-1:0] run_xor;
    logic [CNT_W-1:0]   beat_cnt;
    logic [FAIL_W-1:0]  fail_cnt;
    logic [FAIL_W-1:0]  fail_inc;
    logic               ready;
    logic               accept;
    logic               last_beat;
    logic               sum_ok;
    logic               lockout_hit;

    // Status outputs decode the state register only, so nothing combinational reaches them from inputs.
    assign ready            = (state_q == LOAD) || (state_q == CHECK);
    assign chunk.chunk_ready = ready;
    assign busy             = ready;
    assign key_valid        = (state_q == APPLY);
    assign accept           = chunk.chunk_valid && ready;
    assign last_beat        = (beat_cnt == CNT_W'(N - 1));
    assign sum_ok           = (chunk.chunk_data == run_xor);
    assign fail_inc         = (fail_cnt == FAIL_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;

`ifdef KEY_LOCKOUT_EN
    assign lockout_hit = (fail_inc == FAIL_W'(MAX_FAIL));
    assign locked      = (state_q == LOCKED);
`else
    assign lockout_hit = 1'b0;
    assign locked      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = LOAD;
            LOAD:  if (accept && last_beat) state_d = CHECK;
            CHECK: begin
                if (accept) begin
                    if (sum_ok) begin
                        state_d = APPLY;
                    end else begin
`ifdef KEY_LOCKOUT_EN
                        state_d = lockout_hit ? LOCKED : IDLE;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            APPLY: if (start) state_d = LOAD;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            key_out  <= '0;
            run_xor  <= '0;
            beat_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        shadow   <= '0;
                        run_xor  <= '0;
                        beat_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        for (int k = 0; k < N; k++) begin
                            if (beat_cnt == CNT_W'(k)) begin
                                shadow[k*CHUNK_W +: CHUNK_W] <= chunk.chunk_data;
                            end
                        end
                        run_xor <= run_xor ^ chunk.chunk_data;
                        if (!last_beat) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (sum_ok) begin
                            key_out  <= shadow;
                            fail_cnt <= '0;
                        end else begin
                            err      <= 1'b1;
                            shadow   <= '0;
                            key_out  <= '0;
                            fail_cnt <= fail_inc;
                        end
                    end
                end
                APPLY: begin
                    // Drop the old key on the same edge the reload starts so it is never visible mid-load.
                    if (start) begin
                        key_out  <= '0;
                        shadow   <= '0;
                        run_xor  <= '0;
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    key_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader: a transaction-level model (beat queue, XOR reduce)
// is compared against the DUT every cycle, plus hand-computed literal checks per scenario.
module tb_rll_key_loader;

    localparam int KEY_W    = 32;
    localparam int CHUNK_W  = 8;
    localparam int MAX_FAIL = 3;
    localparam int N        = KEY_W / CHUNK_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [KEY_W-1:0]  key_out;
    logic              key_valid;
    logic              busy;
    logic              err;
    logic              locked;

    int compared   = 0;
    int mismatched = 0;

    rll_key_loader_if #(.CHUNK_W(CHUNK_W)) bus ();

    rll_key_loader #(
        .KEY_W   (KEY_W),
        .CHUNK_W (CHUNK_W),
        .MAX_FAIL(MAX_FAIL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .chunk    (bus.slave),
        .key_out  (key_out),
        .key_valid(key_valid),
        .busy     (busy),
        .err      (err),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    // Behavioural model: phases of a key transaction, accepted beats kept in a queue.
    typedef enum int { M_IDLE, M_COLLECT, M_SUM, M_APPLY, M_LOCK } phase_t;
    phase_t            phase = M_IDLE;
    logic [CHUNK_W-1:0] beats[$];
    logic [KEY_W-1:0]  m_key = '0;
    logic              m_err = 1'b0;
    int                fails = 0;

    function automatic logic [CHUNK_W-1:0] xorOf(input logic [CHUNK_W-1:0] q[$]);
        logic [CHUNK_W-1:0] s = '0;
        foreach (q[i]) s ^= q[i];
        return s;
    endfunction

    function automatic logic [KEY_W-1:0] keyOf(input logic [CHUNK_W-1:0] q[$]);
        logic [KEY_W-1:0] k = '0;
        foreach (q[i]) k[i*CHUNK_W +: CHUNK_W] = q[i];
        return k;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = M_IDLE;
            beats.delete();
            m_key = '0;
            m_err = 1'b0;
            fails = 0;
        end else begin
            m_err = 1'b0;
            case (phase)
                M_IDLE: if (start) begin
                    beats.delete();
                    phase = M_COLLECT;
                end
                M_COLLECT: if (bus.chunk_valid) begin
                    beats.push_back(bus.chunk_data);
                    if (beats.size() == N) phase = M_SUM;
                end
                M_SUM: if (bus.chunk_valid) begin
                    if (bus.chunk_data == xorOf(beats)) begin
                        m_key = keyOf(beats);
                        fails = 0;
                        phase = M_APPLY;
                    end else begin
                        m_err = 1'b1;
                        m_key = '0;
                        fails = (fails + 1 > MAX_FAIL) ? MAX_FAIL : fails + 1;
`ifdef KEY_LOCKOUT_EN
                        phase = (fails >= MAX_FAIL) ? M_LOCK : M_IDLE;
`else
                        phase = M_IDLE;
`endif
                    end
                end
                M_APPLY: if (start) begin
                    m_key = '0;
                    beats.delete();
                    phase = M_COLLECT;
                end
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("model key_out",     key_out,         m_key);
            checkOutput("model key_valid",   32'(key_valid),  32'(phase == M_APPLY));
            checkOutput("model busy",        32'(busy),       32'(phase == M_COLLECT || phase == M_SUM));
            checkOutput("model chunk_ready", 32'(bus.chunk_ready), 32'(phase == M_COLLECT || phase == M_SUM));
            checkOutput("model err",         32'(err),        32'(m_err));
            checkOutput("model locked",      32'(locked),     32'(phase == M_LOCK));
        end
    end

    task automatic applyStimulus(input logic s, input logic v, input logic [CHUNK_W-1:0] d);
        @(negedge clk);
        start           = s;
        bus.chunk_valid = v;
        bus.chunk_data  = d;
    endtask

    // Full transaction; returns at the negedge where outputs reflect the checksum beat.
    task automatic loadKey(input logic [KEY_W-1:0] key, input logic [CHUNK_W-1:0] cs, input bit gappy);
        applyStimulus(1'b1, 1'b0, '0);
        for (int i = 0; i < N; i++) begin
            if (gappy) repeat ($urandom_range(0, 2)) applyStimulus(1'b1, 1'b0, 8'h5A);
            applyStimulus(1'b0, 1'b1, key[i*CHUNK_W +: CHUNK_W]);
        end
        if (gappy) repeat ($urandom_range(1, 2)) applyStimulus(1'b0, 1'b0, 8'hA5);
        applyStimulus(1'b0, 1'b1, cs);
        applyStimulus(1'b0, 1'b0, '0);
    endtask

    task automatic resetPulse();
        @(negedge clk);
        #1 rst = 1'b1;
        #8 rst = 1'b0;
    endtask

    initial begin
        bus.chunk_valid = 1'b0;
        bus.chunk_data  = '0;
        #1 rst = 1'b1;
        #2;
        checkOutput("reset key_out",     key_out,   32'h0);
        checkOutput("reset key_valid",   32'(key_valid), 32'h0);
        checkOutput("reset busy",        32'(busy), 32'h0);
        checkOutput("reset chunk_ready", 32'(bus.chunk_ready), 32'h0);
        checkOutput("reset locked",      32'(locked), 32'h0);
        #19 rst = 1'b0;

        $display("[TB] test 1: good load");
        loadKey(32'hDEADBEEF, 8'h22, 1'b0);
        checkOutput("t1 key_valid", 32'(key_valid), 32'h1);
        checkOutput("t1 key_out",   key_out, 32'hDEADBEEF);

        $display("[TB] test 3: reload from APPLY");
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 8'h01);
        checkOutput("t3 key_out cleared", key_out, 32'h0);
        checkOutput("t3 key_valid low",   32'(key_valid), 32'h0);
        checkOutput("t3 busy",            32'(busy), 32'h1);
        applyStimulus(1'b0, 1'b1, 8'h02);
        applyStimulus(1'b0, 1'b1, 8'h03);
        applyStimulus(1'b0, 1'b1, 8'h04);
        applyStimulus(1'b0, 1'b1, 8'h04);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t3 key_out", key_out, 32'h04030201);
        checkOutput("t3 key_valid", 32'(key_valid), 32'h1);

        $display("[TB] test 2: bad checksum");
        loadKey(32'hDEADBEEF, 8'h23, 1'b0);
        checkOutput("t2 err pulse",  32'(err), 32'h1);
        checkOutput("t2 key_valid",  32'(key_valid), 32'h0);
        checkOutput("t2 key_out",    key_out, 32'h0);
        checkOutput("t2 busy",       32'(busy), 32'h0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t2 err single", 32'(err), 32'h0);

        $display("[TB] test 4: async reset mid-load");
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 8'hEF);
        applyStimulus(1'b0, 1'b1, 8'hBE);
        #1 rst = 1'b1;
        #1;
        checkOutput("t4 busy async",  32'(busy), 32'h0);
        checkOutput("t4 ready async", 32'(bus.chunk_ready), 32'h0);
        checkOutput("t4 key_out",     key_out, 32'h0);
        #6 rst = 1'b0;
        loadKey(32'hDEADBEEF, 8'h22, 1'b0);
        checkOutput("t4 reload key_out", key_out, 32'hDEADBEEF);

        $display("[TB] test 5: gaps and beats in IDLE");
        loadKey(32'h11111111, 8'h01, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b1, 8'hC3);
        checkOutput("t5 idle ready", 32'(bus.chunk_ready), 32'h0);
        loadKey(32'hDEADBEEF, 8'h22, 1'b1);
        checkOutput("t5 key_out",   key_out, 32'hDEADBEEF);
        checkOutput("t5 key_valid", 32'(key_valid), 32'h1);

        $display("[TB] test 6: repeated checksum failures");
        repeat (MAX_FAIL) loadKey(32'hDEADBEEF, 8'h00, 1'b0);
        checkOutput("t6 err third", 32'(err), 32'h1);
`ifdef KEY_LOCKOUT_EN
        checkOutput("t6 locked", 32'(locked), 32'h1);
        applyStimulus(1'b1, 1'b1, 8'hEF);
        applyStimulus(1'b1, 1'b1, 8'hBE);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t6 locked held", 32'(locked), 32'h1);
        checkOutput("t6 ready held",  32'(bus.chunk_ready), 32'h0);
        checkOutput("t6 key_out",     key_out, 32'h0);
        resetPulse();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("t6 unlocked", 32'(locked), 32'h0);
`else
        checkOutput("t6 never locked", 32'(locked), 32'h0);
`endif
        loadKey(32'hCAFEF00D, 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D, 1'b0);
        checkOutput("t6 final key_out", key_out, 32'hCAFEF00D);
        checkOutput("t6 final valid",   32'(key_valid), 32'h1);

        repeat (3) applyStimulus(1'b0, 1'b0, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
